// File: rtl/rtc_mux_bus_master_if.sv
// Request/response and pad-side signals of the multiplexed RTC bus master.
// The master modport is the bus master's view; the slave modport is the
// view of whatever sits around it (port logic plus the tristate pad).
interface rtc_mux_bus_master_if #(
    parameter int DATA_W = 8,
    parameter int BL_W   = 5
);
    // request side
    logic              start;
    logic              rw;
    logic [DATA_W-1:0] addr;
    logic [BL_W-1:0]   burst_len;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [BL_W-1:0]   ridx;

    // pad side
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              ad;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_in;

    modport master (
        input  start, rw, addr, burst_len, wdata, bus_in,
        output busy, done, rdata, rvalid, ridx,
        output cs_n, rd_n, wr_n, ad, bus_out, bus_oe
    );

    modport slave (
        output start, rw, addr, burst_len, wdata, bus_in,
        input  busy, done, rdata, rvalid, ridx,
        input  cs_n, rd_n, wr_n, ad, bus_out, bus_oe
    );
endinterface

// File: rtl/rtc_mux_bus_master.sv
// Multiplexed address/data RTC bus master: one register write or a burst of
// consecutive register reads per request, each byte taking four equal phases.
//
// state | meaning
// IDLE  | waiting for start; request fields captured on start
// ADDR  | address driven on the bus, cs_n/wr_n low, ad=0
// GAP1  | bus released, all strobes high
// DATA  | write data driven (wr_n low) or read strobe low, ad=1
// GAP2  | bus released; then next address or back to IDLE
module rtc_mux_bus_master #(
    parameter int DATA_W    = 8,
    parameter int PHASE_CYC = 10,
    parameter int MAX_BURST = 16,
    parameter int BL_W      = $clog2(MAX_BURST) + 1
) (
    input logic                  clk,
    input logic                  reset,
    rtc_mux_bus_master_if.master bus
);

    localparam int PH_W = $clog2(PHASE_CYC);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_GAP1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_GAP2 = 3'd4;

    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(PHASE_CYC - 1);
    localparam logic [BL_W-1:0] BL_MAX  = BL_W'(MAX_BURST);
    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);

    logic [2:0]        state_q, state_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [BL_W-1:0]   rem_q, rem_d;
    logic [BL_W-1:0]   idx_q, idx_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [BL_W-1:0]   ridx_q, ridx_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              ad_q, ad_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              bus_oe_q, bus_oe_d;

    logic              phase_end;
    logic [BL_W-1:0]   burst_n;

    assign phase_end = (ph_cnt_q == '0);

    // Number of bytes for a new request: writes are always one byte,
    // reads clamp burst_len into 1..MAX_BURST.
    always_comb begin
        burst_n = bus.burst_len;
        if (!bus.rw || (bus.burst_len == '0)) begin
            burst_n = BL_ONE;
        end else if (bus.burst_len > BL_MAX) begin
            burst_n = BL_MAX;
        end
    end

    // Sequencing: phase down-counter plus per-byte address/count bookkeeping.
    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        ridx_d   = ridx_q;
        rvalid_d = 1'b0;
        done_d   = 1'b0;

        if (state_q != S_IDLE) begin
            ph_cnt_d = phase_end ? PH_LOAD : (ph_cnt_q - PH_W'(1));
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.addr;
                    wdata_d  = bus.wdata;
                    rw_d     = bus.rw;
                    rem_d    = burst_n;
                    idx_d    = '0;
                    ph_cnt_d = PH_LOAD;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (phase_end) state_d = S_GAP1;
            end
            S_GAP1: begin
                if (phase_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (phase_end) begin
                    state_d = S_GAP2;
                    // the pad value is taken on the edge closing the strobe
                    if (rw_q) begin
                        rdata_d  = bus.bus_in;
                        rvalid_d = 1'b1;
                        ridx_d   = idx_q;
                    end
                end
            end
            S_GAP2: begin
                if (phase_end) begin
                    if (rem_q == BL_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d   = rem_q - BL_ONE;
                        idx_d   = idx_q + BL_ONE;
                        addr_d  = addr_q + DATA_W'(1);
                        state_d = S_ADDR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus-side outputs decoded from the next state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        ad_d      = 1'b0;
        bus_oe_d  = 1'b0;
        bus_out_d = '0;
        busy_d    = (state_d != S_IDLE);

        case (state_d)
            S_ADDR: begin
                cs_n_d    = 1'b0;
                wr_n_d    = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = addr_d;
            end
            S_DATA: begin
                cs_n_d = 1'b0;
                ad_d   = 1'b1;
                if (rw_d) begin
                    rd_n_d = 1'b0;
                end else begin
                    wr_n_d    = 1'b0;
                    bus_oe_d  = 1'b1;
                    bus_out_d = wdata_d;
                end
            end
            default: begin
                cs_n_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ph_cnt_q  <= PH_LOAD;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            rem_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            ridx_q    <= '0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_q      <= 1'b0;
            bus_out_q <= '0;
            bus_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_cnt_q  <= ph_cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            ridx_q    <= ridx_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            ad_q      <= ad_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.ridx    = ridx_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.rd_n    = rd_n_q;
    assign bus.wr_n    = wr_n_q;
    assign bus.ad      = ad_q;
    assign bus.bus_out = bus_out_q;
    assign bus.bus_oe  = bus_oe_q;

endmodule

// File: tb/tb_rtc_mux_bus_master.sv
// Bench for rtc_mux_bus_master: an RTC register model on the pad, and a
// cycle-number based expectation of every bus and status output.
module tb_rtc_mux_bus_master;

    localparam int DW  = 8;
    localparam int P   = 4;
    localparam int MB  = 16;
    localparam int BLW = $clog2(MB) + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    rtc_mux_bus_master_if #(.DATA_W(DW), .BL_W(BLW)) ifc ();

    rtc_mux_bus_master #(
        .DATA_W   (DW),
        .PHASE_CYC(P),
        .MAX_BURST(MB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_mem  [256];
    logic [7:0] seed_mem [256];
    logic [7:0] rtc_mem  [256];
    logic [7:0] rtc_addr = 8'h00;
    logic       seed_en  = 1'b0;
    logic [7:0] exp_rdata = 8'h00;

    // RTC chip model: latches the address in the address phase, stores
    // write data in a write data phase, and returns the addressed register.
    always @(posedge clk) begin
        if (seed_en) begin
            for (int i = 0; i < 256; i++) rtc_mem[i] <= seed_mem[i];
        end else begin
            if (!ifc.cs_n && !ifc.ad && ifc.bus_oe) rtc_addr <= ifc.bus_out;
            if (!ifc.cs_n && !ifc.wr_n && ifc.ad && ifc.bus_oe) rtc_mem[rtc_addr] <= ifc.bus_out;
        end
    end

    assign ifc.bus_in = rtc_mem[rtc_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},   32'(ifc.busy),   32'd0);
        chk({tag, "_done"},   32'(ifc.done),   32'd0);
        chk({tag, "_rvalid"}, 32'(ifc.rvalid), 32'd0);
        chk({tag, "_cs_n"},   32'(ifc.cs_n),   32'd1);
        chk({tag, "_rd_n"},   32'(ifc.rd_n),   32'd1);
        chk({tag, "_wr_n"},   32'(ifc.wr_n),   32'd1);
        chk({tag, "_oe"},     32'(ifc.bus_oe), 32'd0);
        chk({tag, "_rdata"},  32'(ifc.rdata),  32'(exp_rdata));
    endtask

    task automatic idle(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check_idle("idle");
        end
    endtask

    // Expected outputs in cycle c of an n-byte transaction, from the
    // four-phase-per-byte timing.
    task automatic check_cycle(input int c, input int n, input logic rw,
                               input logic [7:0] a, input logic [7:0] wd);
        int k, off, ph;
        logic [7:0] ak;
        logic e_cs, e_rd, e_wr, e_ad, e_oe;
        logic [7:0] e_out;
        if (c == 4 * P * n + 1) begin
            chk("done_pulse", 32'(ifc.done),   32'd1);
            chk("done_busy",  32'(ifc.busy),   32'd0);
            chk("done_cs_n",  32'(ifc.cs_n),   32'd1);
            chk("done_oe",    32'(ifc.bus_oe), 32'd0);
            chk("done_rvld",  32'(ifc.rvalid), 32'd0);
            chk("done_rdata", 32'(ifc.rdata),  32'(exp_rdata));
            return;
        end
        k   = (c - 1) / (4 * P);
        off = (c - 1) % (4 * P);
        ph  = off / P;
        ak  = a + 8'(k);
        e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_ad = 1'b0; e_oe = 1'b0; e_out = 8'h00;
        if (ph == 0) begin
            e_cs = 1'b0; e_wr = 1'b0; e_oe = 1'b1; e_out = ak;
        end else if (ph == 2) begin
            e_cs = 1'b0; e_ad = 1'b1;
            if (rw) e_rd = 1'b0;
            else begin
                e_wr = 1'b0; e_oe = 1'b1; e_out = wd;
            end
        end
        chk("busy",   32'(ifc.busy),   32'd1);
        chk("done",   32'(ifc.done),   32'd0);
        chk("cs_n",   32'(ifc.cs_n),   32'(e_cs));
        chk("rd_n",   32'(ifc.rd_n),   32'(e_rd));
        chk("wr_n",   32'(ifc.wr_n),   32'(e_wr));
        chk("ad",     32'(ifc.ad),     32'(e_ad));
        chk("bus_oe", 32'(ifc.bus_oe), 32'(e_oe));
        if (e_oe) chk("bus_out", 32'(ifc.bus_out), 32'(e_out));
        if (rw && off == 3 * P) begin
            exp_rdata = ref_mem[ak];
            chk("rvalid", 32'(ifc.rvalid), 32'd1);
            chk("ridx",   32'(ifc.ridx),   32'(k));
        end else begin
            chk("rvalid", 32'(ifc.rvalid), 32'd0);
        end
        chk("rdata", 32'(ifc.rdata), 32'(exp_rdata));
    endtask

    // Must be called inside the cycle that becomes cycle 0. Returns at the
    // negative edge of the done cycle (or after a reset abort).
    task automatic run_txn(input logic rw, input logic [7:0] a, input int bl,
                           input logic [7:0] wd, input int pulse_c, input int abort_c);
        int n;
        int rv_cnt;
        rv_cnt = 0;
        if (!rw || bl == 0) n = 1;
        else if (bl > MB) n = MB;
        else n = bl;
        ifc.start     = 1'b1;
        ifc.rw        = rw;
        ifc.addr      = a;
        ifc.burst_len = BLW'(bl);
        ifc.wdata     = wd;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        for (int c = 1; c <= 4 * P * n + 1; c++) begin
            @(negedge clk);
            check_cycle(c, n, rw, a, wd);
            if (ifc.rvalid) rv_cnt++;
            if (c == abort_c) begin
                #2 reset = 1'b0;
                #1;
                chk("rst_cs_n",   32'(ifc.cs_n),   32'd1);
                chk("rst_rd_n",   32'(ifc.rd_n),   32'd1);
                chk("rst_wr_n",   32'(ifc.wr_n),   32'd1);
                chk("rst_oe",     32'(ifc.bus_oe), 32'd0);
                chk("rst_busy",   32'(ifc.busy),   32'd0);
                chk("rst_done",   32'(ifc.done),   32'd0);
                chk("rst_rdata",  32'(ifc.rdata),  32'd0);
                exp_rdata = 8'h00;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("rst_hold_done", 32'(ifc.done), 32'd0);
                    chk("rst_hold_busy", 32'(ifc.busy), 32'd0);
                end
                reset = 1'b1;
                return;
            end
            if (c == pulse_c) begin
                ifc.start = 1'b1;
                ifc.rw    = ~rw;
                ifc.addr  = a + 8'h40;
            end else if (c == pulse_c + 1) begin
                ifc.start = 1'b0;
            end
        end
        chk("rvalid_count", 32'(rv_cnt), rw ? 32'(n) : 32'd0);
        if (!rw) ref_mem[a] = wd;
    endtask

    initial begin
        logic       r_rw;
        logic [7:0] r_a, r_wd;
        int         r_bl;

        ifc.start = 1'b0; ifc.rw = 1'b0; ifc.addr = 8'h00;
        ifc.burst_len = '0; ifc.wdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            seed_mem[i] = 8'(i + 16);
            ref_mem[i]  = seed_mem[i];
        end
        seed_en = 1'b1;

        repeat (3) @(negedge clk);
        seed_en = 1'b0;
        check_idle("reset");
        chk("reset_ad",      32'(ifc.ad),      32'd0);
        chk("reset_bus_out", 32'(ifc.bus_out), 32'd0);
        chk("reset_ridx",    32'(ifc.ridx),    32'd0);
        reset = 1'b1;
        idle(2);

        // read 0x21 x3 with an ignored start at cycle 5, then a write
        // started in the done cycle
        run_txn(1'b1, 8'h21, 3, 8'h00, 5, 0);
        chk("burst_last_rdata", 32'(ifc.rdata), 32'h33);
        run_txn(1'b0, 8'h22, 0, 8'h45, 0, 0);
        idle(2);

        // address wrap 0xFF -> 0x00
        run_txn(1'b1, 8'hFF, 2, 8'h00, 0, 0);
        chk("wrap_rdata", 32'(ifc.rdata), 32'h10);
        idle(1);

        // burst_len 0 and oversize burst_len
        run_txn(1'b1, 8'h05, 0, 8'h00, 0, 0);
        idle(1);
        run_txn(1'b1, 8'h80, 31, 8'h00, 0, 0);
        idle(1);

        // read back the earlier write
        run_txn(1'b1, 8'h22, 1, 8'h00, 0, 0);
        chk("readback", 32'(ifc.rdata), 32'h45);
        idle(1);

        // reset during the DATA phase of a read, then a fresh write
        run_txn(1'b1, 8'h30, 2, 8'h00, 0, 2 * P + 2);
        idle(2);
        run_txn(1'b0, 8'h50, 0, 8'hA5, 0, 0);
        idle(2);

        // randomized transactions over randomized register contents
        for (int i = 0; i < 256; i++) begin
            seed_mem[i] = 8'($urandom);
            ref_mem[i]  = seed_mem[i];
        end
        ref_mem[8'h50] = 8'hA5;
        seed_mem[8'h50] = 8'hA5;
        seed_en = 1'b1;
        @(negedge clk);
        seed_en = 1'b0;
        for (int t = 0; t < 12; t++) begin
            r_rw = 1'($urandom_range(0, 1));
            r_a  = 8'($urandom);
            r_bl = int'($urandom_range(0, 20));
            r_wd = 8'($urandom);
            run_txn(r_rw, r_a, r_bl, r_wd, 0, 0);
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_mux_bus_master.md
# rtc_mux_bus_master

Parametrised master for a multiplexed address/data RTC bus: chip-select, read strobe, write strobe and address/data-select lines over one shared bus. A single request performs either one register write or a burst of consecutive register reads. Each read is returned on a valid-pulsed output together with its burst index. The block sits between the PicoBlaze port logic and the top-level tristate pad. Phase timing and burst depth are set by parameters.

## Interface
- DATA_W, 8, width of address/data bus and registers
- PHASE_CYC, 10, clk cycles per bus phase (legal range ≥ 2)
- MAX_BURST, 16, largest read burst; BL_W = $clog2(MAX_BURST)+1
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request strobe, sampled only in IDLE
- rw  in  1  1 = read burst, 0 = single write
- addr  in  DATA_W  first RTC register address
- burst_len  in  BL_W  number of reads (ignored for writes)
- wdata  in  DATA_W  write data
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at completion
- rdata  out  DATA_W  last byte read
- rvalid  out  1  one-cycle pulse, rdata/ridx valid
- ridx  out  BL_W  index of rdata within burst (0-based)
- cs_n  out  1  chip select, active low
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- ad  out  1  0 = address phase, 1 = data phase
- bus_out  out  DATA_W  value driven on the pad
- bus_oe  out  1  pad output enable
- bus_in  in  DATA_W  pad input value

## Operation
- FSM states: IDLE, ADDR, GAP1, DATA, GAP2.
- Each state except IDLE lasts exactly PHASE_CYC cycles, timed by the phase counter.
- IDLE
  - start=1 captures addr, wdata and rw.
  - It latches N = burst_len for reads, or N = 1 for writes.
  - burst_len = 0 is treated as 1; burst_len > MAX_BURST is clamped to MAX_BURST.
  - The FSM then moves to ADDR.
- ADDR: cs_n=0, wr_n=0, rd_n=1, ad=0, bus_oe=1, bus_out = current address.
- GAP1 and GAP2: cs_n=rd_n=wr_n=1, ad=0, bus_oe=0.
- DATA (write): cs_n=0, wr_n=0, ad=1, bus_oe=1, bus_out=wdata.
- DATA (read): cs_n=0, rd_n=0, ad=1, bus_oe=0. bus_in is registered into rdata on the clock edge that ends the last DATA cycle.
- GAP2 end
  - If bytes remain: address increments modulo 2^DATA_W (0xFF→0x00) and the FSM returns to ADDR.
  - Otherwise the FSM returns to IDLE.
- start while busy is ignored; it is not queued.
- All bus-side outputs are registered, so there are no combinational glitches on strobes.
- Reset values
  - IDLE state; busy=0, done=0, rvalid=0.
  - rdata=0, ridx=0, bus_out=0, bus_oe=0.
  - cs_n=rd_n=wr_n=1, ad=0.
- A reset asserted mid-transaction forces these values immediately (asynchronously) and abandons the transaction; no done pulse is produced.

## Timing
- Let P = PHASE_CYC. Cycle 0 is the cycle in which start is sampled high.
- Byte k (0-based) of the transaction:
  - ADDR occupies cycles 4Pk+1 .. 4Pk+P.
  - GAP1 occupies cycles 4Pk+P+1 .. 4Pk+2P.
  - DATA occupies cycles 4Pk+2P+1 .. 4Pk+3P.
  - GAP2 occupies cycles 4Pk+3P+1 .. 4Pk+4P.
- Read byte k: rvalid=1 and ridx=k in cycle 4Pk+3P+1 only.
- busy=1 in cycles 1 .. 4PN.
- done=1 and busy=0 in cycle 4PN+1; the FSM is in IDLE in that cycle.
- A start in the done cycle is accepted; that cycle becomes the new cycle 0.
- Latency figures:
  - start to first rvalid = 3P+1 cycles.
  - Write start to done = 4P+1 cycles.
- rdata holds its value until the next capture.

## Test plan
- P=4, read burst_len=3, addr=0x21, bus_in model returns 0x10+address:
  - rvalid at cycles 13, 29, 45 with rdata 0x31, 0x32, 0x33 and ridx 0, 1, 2.
  - done at cycle 49.
  - cs_n low for exactly 4 cycles per phase.
- Write, P=4, addr=0x22, wdata=0x45:
  - bus_out=0x22 with bus_oe=1 and ad=0 in cycles 1–4.
  - bus_out=0x45 with wr_n=0 and ad=1 in cycles 9–12.
  - rd_n stays 1 throughout; done at cycle 17; rvalid is never asserted.
- Read burst_len=2, addr=0xFF: addresses 0xFF then 0x00 are driven.
- burst_len=0 yields 1 read; burst_len=31 with MAX_BURST=16 yields exactly 16 rvalids.
- start pulsed at cycle 5 during a busy read has no effect; start in the done cycle begins a new ADDR in the next cycle.
- reset deasserted→asserted (driven low) during DATA of a read:
  - cs_n, rd_n and wr_n go high and bus_oe goes 0 without waiting for a clock edge.
  - busy=0 and no done pulse.
  - After reset release, a fresh write completes normally.
